// File: rtl/modulo_updown_counter.sv
// Synchronous modulo up/down counter: load with clamp, wrap or saturate, tc pulse, sticky flags.
// Define MODULO_UPDOWN_COUNTER_GRAY_OUT_EN to add a registered Gray-coded copy of Q (gray_q).
module modulo_updown_counter #(
  parameter int                       COUNTER_WIDTH = 8,
  parameter longint unsigned          MODULUS       = 256,
  parameter logic [COUNTER_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     up_down,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] load_value,
  input  logic                     sat_mode,
  input  logic                     clear_flags,
  output logic [COUNTER_WIDTH-1:0] Q,
  output logic                     tc,
  output logic                     overflow,
  output logic                     underflow
`ifdef MODULO_UPDOWN_COUNTER_GRAY_OUT_EN
  ,
  output logic [COUNTER_WIDTH-1:0] gray_q
`endif
);

  // Top of range kept one bit wider so MODULUS == 2**COUNTER_WIDTH needs no special case.
  localparam logic [COUNTER_WIDTH:0] TOP = (COUNTER_WIDTH+1)'(MODULUS - 64'd1);

  logic [COUNTER_WIDTH:0]   q_ext, ld_ext;
  logic [COUNTER_WIDTH-1:0] q_nxt;
  logic                     tc_nxt, ovf_nxt, unf_nxt;

  assign q_ext  = {1'b0, Q};
  assign ld_ext = {1'b0, load_value};

  always_comb begin
    q_nxt   = Q;
    tc_nxt  = 1'b0;
    ovf_nxt = overflow  & ~clear_flags;
    unf_nxt = underflow & ~clear_flags;
    if (load) begin
      q_nxt = (ld_ext > TOP) ? TOP[COUNTER_WIDTH-1:0] : load_value;
    end else if (en) begin
      if (up_down) begin
        if (q_ext == TOP) begin
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
          if (!sat_mode) q_nxt = '0;
        end else begin
          q_nxt = COUNTER_WIDTH'(q_ext + (COUNTER_WIDTH+1)'(1));
        end
      end else begin
        if (q_ext == '0) begin
          tc_nxt  = 1'b1;
          unf_nxt = 1'b1;
          if (!sat_mode) q_nxt = TOP[COUNTER_WIDTH-1:0];
        end else begin
          q_nxt = COUNTER_WIDTH'(q_ext - (COUNTER_WIDTH+1)'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Q         <= RESET_VALUE;
      tc        <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      Q         <= q_nxt;
      tc        <= tc_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

`ifdef MODULO_UPDOWN_COUNTER_GRAY_OUT_EN
  // Encoded from q_nxt so the Gray word lands on the same edge as Q.
  always_ff @(posedge clk) begin
    if (reset) gray_q <= RESET_VALUE ^ (RESET_VALUE >> 1);
    else       gray_q <= q_nxt ^ (q_nxt >> 1);
  end
`endif

endmodule
